// File: rtl/csr_bus_master_if.sv
// ---------------------------------------------------------------------------
// csr_bus_master_if
//
// Bundles the signals around csr_bus_master:
//   request  : req_valid/req_ready handshake with req_addr, req_op, req_wdata,
//              req_rd_zero, req_rs_zero
//   response : rsp_valid/rsp_ready handshake with rsp_rdata, rsp_illegal
//   CSR bus  : csr_read, csr_modify, csr_wdata, csr_addr out;
//              csr_rdata, csr_valid back (wired-OR of all responders)
//
// Modports:
//   master : the view taken by csr_bus_master
//   slave  : the view taken by the environment (requester, consumer, responders)
// ---------------------------------------------------------------------------
interface csr_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_wdata;
    logic        req_rd_zero;
    logic        req_rs_zero;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;

    logic        csr_read;
    logic [2:0]  csr_modify;
    logic [31:0] csr_wdata;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata;
    logic        csr_valid;

    modport master (
        input  req_valid, req_addr, req_op, req_wdata, req_rd_zero, req_rs_zero,
        input  rsp_ready, csr_rdata, csr_valid,
        output req_ready, rsp_valid, rsp_rdata, rsp_illegal,
        output csr_read, csr_modify, csr_wdata, csr_addr
    );

    modport slave (
        output req_valid, req_addr, req_op, req_wdata, req_rd_zero, req_rs_zero,
        output rsp_ready, csr_rdata, csr_valid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_illegal,
        input  csr_read, csr_modify, csr_wdata, csr_addr
    );
endinterface

// File: rtl/csr_bus_master.sv
// ---------------------------------------------------------------------------
// csr_bus_master
//
// Turns one CSR instruction request (write / set / clear) into a single-cycle
// access on a shared CSR bus, captures the responders' wired-OR answer one
// cycle later and returns the old CSR value plus a fault flag to the consumer.
//
// Ports:
//   clk  : single clock, rising-edge
//   rst  : asynchronous active-high reset; aborts any transaction and drops
//          bus drive immediately
//   bus  : csr_bus_master_if.master -- request, response and CSR bus signals
//
// Sequence: IDLE (accept) -> ACCESS (bus driven 1 cycle) -> CAPTURE (sample
// csr_rdata/csr_valid) -> RESP (hold until rsp_ready) -> IDLE.
// Reserved op 00 goes straight from IDLE to RESP as an illegal access.
//
// Optional feature, macro CSR_BUS_MASTER_RO_CHECK_EN: a request that would
// write (eff_write) to the read-only CSR range addr[11:10]==2'b11 is faulted
// locally without touching the bus. Undefined: such writes go on the bus and
// the responders decide.
// ---------------------------------------------------------------------------
module csr_bus_master (
    input  logic                   clk,
    input  logic                   rst,
    csr_bus_master_if.master       bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [1:0] OP_RESERVED = 2'b00;
    localparam logic [1:0] OP_WRITE    = 2'b01;

    state_t      state_reg;
    logic        req_ready_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_rdata_reg;
    logic        rsp_illegal_reg;
    logic        csr_read_reg;
    logic [2:0]  csr_modify_reg;
    logic [31:0] csr_wdata_reg;
    logic [11:0] csr_addr_reg;

    // Effective access type of the request currently on the input.
    // A plain write (csrrw) always writes even from x0; set/clear from x0
    // are pure reads. Only csrrw with rd=x0 suppresses the read.
    logic eff_write;
    logic eff_read;
    logic ro_block;
    logic accept;

    always_comb begin
        eff_write = (bus.req_op == OP_WRITE) ||
                    ((bus.req_op != OP_RESERVED) && !bus.req_rs_zero);
        eff_read  = !bus.req_rd_zero || (bus.req_op != OP_WRITE);
    end

`ifdef CSR_BUS_MASTER_RO_CHECK_EN
    assign ro_block = eff_write && (bus.req_addr[11:10] == 2'b11);
`else
    assign ro_block = 1'b0;
`endif

    // req_ready_reg is only ever high in IDLE, so this is the handshake.
    assign accept = bus.req_valid && req_ready_reg;

    // The bus-side output registers double as the latched request fields:
    // they are loaded on acceptance, presented during ACCESS and cleared on
    // the way out of ACCESS, so the bus is idle in every other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            req_ready_reg   <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= 32'h0;
            rsp_illegal_reg <= 1'b0;
            csr_read_reg    <= 1'b0;
            csr_modify_reg  <= 3'b000;
            csr_wdata_reg   <= 32'h0;
            csr_addr_reg    <= 12'h000;
        end else begin
            case (state_reg)
                IDLE: begin
                    // First edge after reset release raises req_ready.
                    req_ready_reg <= 1'b1;
                    if (accept) begin
                        req_ready_reg <= 1'b0;
                        if ((bus.req_op == OP_RESERVED) || ro_block) begin
                            // Faulted locally: no bus cycle, answer next cycle.
                            state_reg       <= RESP;
                            rsp_valid_reg   <= 1'b1;
                            rsp_rdata_reg   <= 32'h0;
                            rsp_illegal_reg <= 1'b1;
                        end else begin
                            state_reg      <= ACCESS;
                            csr_addr_reg   <= bus.req_addr;
                            csr_read_reg   <= eff_read;
                            csr_modify_reg <= eff_write ? {1'b0, bus.req_op} : 3'b000;
                            csr_wdata_reg  <= bus.req_wdata;
                        end
                    end
                end

                ACCESS: begin
                    state_reg      <= CAPTURE;
                    csr_addr_reg   <= 12'h000;
                    csr_read_reg   <= 1'b0;
                    csr_modify_reg <= 3'b000;
                    csr_wdata_reg  <= 32'h0;
                end

                CAPTURE: begin
                    // rdata is taken as-is even when nobody answered; the
                    // illegal flag alone marks the fault.
                    state_reg       <= RESP;
                    rsp_valid_reg   <= 1'b1;
                    rsp_rdata_reg   <= bus.csr_rdata;
                    rsp_illegal_reg <= !bus.csr_valid;
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_rdata   = rsp_rdata_reg;
    assign bus.rsp_illegal = rsp_illegal_reg;
    assign bus.csr_read    = csr_read_reg;
    assign bus.csr_modify  = csr_modify_reg;
    assign bus.csr_wdata   = csr_wdata_reg;
    assign bus.csr_addr    = csr_addr_reg;

endmodule

// File: tb/tb_csr_bus_master.sv
// ---------------------------------------------------------------------------
// tb_csr_bus_master
//
// Drives csr_bus_master through its interface with directed scenarios and
// randomized requests. A small CSR responder (registered, one-cycle answer)
// sits on the bus. Expected bus cycles and responses are computed from the
// request rules and a reference copy of the CSR contents, queued at issue
// time, and checked by an independent monitor.
// ---------------------------------------------------------------------------
module tb_csr_bus_master;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    csr_bus_master_if bus();

    csr_bus_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
        int          first_cyc;
    } rsp_t;

    typedef struct {
        logic [11:0] addr;
        logic        rd;
        logic [2:0]  mod;
        logic [31:0] wdata;
        int          cyc;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];

    logic [31:0] ref_mem [int];   // reference CSR contents
    logic [31:0] dev_mem [int];   // responder's own CSR contents

    int last_acc;
    int bp_cnt;
    bit rand_ready;
    bit seen;
    bit expect_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- CSR responder ----------------
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.csr_valid <= 1'b0;
            bus.csr_rdata <= 32'h0;
        end else if ((bus.csr_read || bus.csr_modify != 3'b000) &&
                     dev_mem.exists(int'(bus.csr_addr))) begin
            bus.csr_valid <= 1'b1;
            bus.csr_rdata <= bus.csr_read ? dev_mem[int'(bus.csr_addr)] : 32'h0;
            case (bus.csr_modify)
                3'b001: dev_mem[int'(bus.csr_addr)] = bus.csr_wdata;
                3'b010: dev_mem[int'(bus.csr_addr)] = dev_mem[int'(bus.csr_addr)] | bus.csr_wdata;
                3'b011: dev_mem[int'(bus.csr_addr)] = dev_mem[int'(bus.csr_addr)] & ~bus.csr_wdata;
                default: ;
            endcase
        end else begin
            bus.csr_valid <= 1'b0;
            bus.csr_rdata <= 32'h0;
        end
    end

    // ---------------- response consumer ----------------
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bp_cnt > 0) begin
                bus.rsp_ready = 1'b0;
                if (bus.rsp_valid) bp_cnt--;
            end else if (rand_ready) begin
                bus.rsp_ready = ($urandom_range(3) != 0);
            end else begin
                bus.rsp_ready = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bus_t b;
        rsp_t r;
        forever begin
            @(negedge clk);
            #1;
            if (rst) continue;

            if (bus.csr_read || bus.csr_modify != 3'b000) begin
                if (bus_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected actual addr=0x%03h modify=%0d read=%0d required=no activity (cycle %0d)",
                             bus.csr_addr, bus.csr_modify, bus.csr_read, cyc);
                end else begin
                    b = bus_q.pop_front();
                    check("bus_addr",   32'(bus.csr_addr),   32'(b.addr));
                    check("bus_read",   32'(bus.csr_read),   32'(b.rd));
                    check("bus_modify", 32'(bus.csr_modify), 32'(b.mod));
                    check("bus_wdata",  bus.csr_wdata,       b.wdata);
                    check("bus_cycle",  32'(cyc),            32'(b.cyc));
                end
            end else begin
                check("bus_idle_addr",  32'(bus.csr_addr), 32'h0);
                check("bus_idle_wdata", bus.csr_wdata,     32'h0);
                if (bus_q.size() > 0 && bus_q[0].cyc < cyc) begin
                    checks++; errors++;
                    $display("FAIL bus_missing actual=none required=addr 0x%03h in cycle %0d", bus_q[0].addr, bus_q[0].cyc);
                    void'(bus_q.pop_front());
                end
            end

            if (expect_ready) begin
                check("req_ready_after_handshake", 32'(bus.req_ready), 32'h1);
                expect_ready = 1'b0;
            end

            if (bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected actual rdata=0x%08h illegal=%0d required=no response (cycle %0d)",
                             bus.rsp_rdata, bus.rsp_illegal, cyc);
                end else begin
                    r = rsp_q[0];
                    if (!seen) begin
                        check("rsp_latency", 32'(cyc), 32'(r.first_cyc));
                        seen = 1'b1;
                    end
                    check("rsp_rdata",           bus.rsp_rdata,          r.rdata);
                    check("rsp_illegal",         32'(bus.rsp_illegal),   32'(r.illegal));
                    check("req_ready_while_rsp", 32'(bus.req_ready),     32'h0);
                    if (bus.rsp_ready) begin
                        void'(rsp_q.pop_front());
                        seen = 1'b0;
                        expect_ready = 1'b1;
                        $display("rsp  rdata=0x%08h illegal=%0d cycle=%0d", bus.rsp_rdata, bus.rsp_illegal, cyc);
                    end
                end
            end else if (rsp_q.size() > 0 && !seen && cyc > rsp_q[0].first_cyc) begin
                checks++; errors++;
                $display("FAIL rsp_missing actual=none required=response by cycle %0d (cycle %0d)", rsp_q[0].first_cyc, cyc);
                void'(rsp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus + reference model ----------------
    task automatic issue(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wdata,
                         input logic rdz, input logic rsz);
        int          n;
        bit          wr, rd, blk, mapped;
        logic [31:0] old;
        rsp_t        r;
        bus_t        b;
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_addr    = addr;
        bus.req_op      = op;
        bus.req_wdata   = wdata;
        bus.req_rd_zero = rdz;
        bus.req_rs_zero = rsz;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=req_ready 0 required=acceptance within 200 cycles");
            bus.req_valid = 1'b0;
            return;
        end
        last_acc = cyc;
        $display("req  addr=0x%03h op=%0d wdata=0x%08h rd_zero=%0d rs_zero=%0d cycle=%0d", addr, op, wdata, rdz, rsz, cyc);

        // csrrw always writes; csrrs/csrrc write unless the source is x0.
        wr  = (op == 2'b01) || (op != 2'b00 && !rsz);
        // Only csrrw to x0 skips the read.
        rd  = !rdz || (op != 2'b01);
        blk = 1'b0;
`ifdef CSR_BUS_MASTER_RO_CHECK_EN
        blk = wr && (addr[11:10] == 2'b11);
`endif
        if (op == 2'b00 || blk) begin
            r.rdata = 32'h0; r.illegal = 1'b1; r.first_cyc = last_acc + 1;
            rsp_q.push_back(r);
        end else begin
            b.addr = addr; b.rd = rd; b.mod = wr ? {1'b0, op} : 3'b000;
            b.wdata = wdata; b.cyc = last_acc + 1;
            bus_q.push_back(b);
            mapped = ref_mem.exists(int'(addr));
            old    = mapped ? ref_mem[int'(addr)] : 32'h0;
            r.rdata     = (mapped && rd) ? old : 32'h0;
            r.illegal   = !mapped;
            r.first_cyc = last_acc + 3;
            rsp_q.push_back(r);
            if (mapped && wr) begin
                if (op == 2'b01)      ref_mem[int'(addr)] = wdata;
                else if (op == 2'b10) ref_mem[int'(addr)] = old | wdata;
                else                  ref_mem[int'(addr)] = old & ~wdata;
            end
        end
    endtask

    task automatic idle_req();
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rsp_q.size() != 0 || bus_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0 pending", rsp_q.size() + bus_q.size());
            rsp_q.delete();
            bus_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},   32'(bus.req_ready),   32'h0);
        check({tag, "_rsp_valid"},   32'(bus.rsp_valid),   32'h0);
        check({tag, "_rsp_rdata"},   bus.rsp_rdata,        32'h0);
        check({tag, "_rsp_illegal"}, 32'(bus.rsp_illegal), 32'h0);
        check({tag, "_csr_read"},    32'(bus.csr_read),    32'h0);
        check({tag, "_csr_modify"},  32'(bus.csr_modify),  32'h0);
        check({tag, "_csr_addr"},    32'(bus.csr_addr),    32'h0);
        check({tag, "_csr_wdata"},   bus.csr_wdata,        32'h0);
    endtask

    // Pulse reset "offset" cycles after acceptance (1 = ACCESS, 2 = CAPTURE).
    task automatic reset_mid(input int offset);
        issue(12'hC00, 2'b10, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (cyc < last_acc + offset) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        rsp_q.delete();
        bus_q.delete();
        seen = 1'b0;
        expect_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("req_ready_at_release", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        #1;
        check("req_ready_after_release", 32'(bus.req_ready), 32'h1);
        $display("rst  mid-transaction pulse at offset %0d done cycle=%0d", offset, cyc);
    endtask

    function automatic logic [11:0] pick_addr();
        logic [11:0] a;
        case ($urandom_range(9))
            0: a = 12'hC00;
            1: a = 12'hBC1;
            2: a = 12'hF11;
            3: a = 12'h300;
            4: a = 12'h341;
            5: a = 12'h305;
            6: a = 12'h123;
            default: a = 12'($urandom_range(4095));
        endcase
        return a;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=still running required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; bp_cnt = 0; rand_ready = 1'b0;
        seen = 1'b0; expect_ready = 1'b0; last_acc = 0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_op = '0;
        bus.req_wdata = '0; bus.req_rd_zero = 1'b0; bus.req_rs_zero = 1'b0;

        ref_mem[12'hC00] = 32'h0000_1234; dev_mem[12'hC00] = 32'h0000_1234;
        ref_mem[12'hBC1] = 32'hCAFE_0001; dev_mem[12'hBC1] = 32'hCAFE_0001;
        ref_mem[12'hF11] = 32'h0000_0611; dev_mem[12'hF11] = 32'h0000_0611; // VENDORID
        ref_mem[12'h300] = 32'h0000_1800; dev_mem[12'h300] = 32'h0000_1800;
        ref_mem[12'h341] = 32'h8000_0040; dev_mem[12'h341] = 32'h8000_0040;
        ref_mem[12'h305] = 32'h0000_0100; dev_mem[12'h305] = 32'h0000_0100;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("req_ready_before_first_edge", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        #1;
        check("req_ready_first_edge", 32'(bus.req_ready), 32'h1);

        // read via csrrs from x0
        issue(12'hC00, 2'b10, 32'hFFFF_FFFF, 1'b0, 1'b1);
        // plain write, old value returned
        issue(12'hBC1, 2'b01, 32'h0000_0005, 1'b0, 1'b0);
        // unmapped address
        issue(12'h123, 2'b10, 32'h0, 1'b0, 1'b1);
        // reserved op
        issue(12'hC00, 2'b00, 32'h1, 1'b0, 1'b0);
        // write to read-only range
        issue(12'hF11, 2'b01, 32'h0000_DEAD, 1'b0, 1'b0);
        // set and clear with a real source
        issue(12'h300, 2'b10, 32'h0000_0008, 1'b0, 1'b0);
        issue(12'h300, 2'b11, 32'h0000_1000, 1'b0, 1'b0);
        // csrrw to x0: no read
        issue(12'h305, 2'b01, 32'h0000_0200, 1'b1, 1'b0);
        idle_req();
        wait_drain();

        // backpressure: five cycles of rsp_ready low while the response waits
        bp_cnt = 5;
        issue(12'h341, 2'b10, 32'h0, 1'b0, 1'b1);
        issue(12'hC00, 2'b10, 32'h0, 1'b0, 1'b1);
        idle_req();
        wait_drain();

        reset_mid(1);
        reset_mid(2);
        wait_drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            issue(pick_addr(), 2'($urandom_range(3)), $urandom,
                  1'($urandom_range(1)), 1'($urandom_range(1)));
            if ($urandom_range(3) == 0) begin
                idle_req();
                repeat ($urandom_range(3)) @(negedge clk);
            end
        end
        idle_req();
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
